// File: rtl/conv_layer_seq.sv
// Sequences one conv layer pass as 2*OH half-row launches, capturing each half-row into fmap.
// Each half-row takes 1 ISSUE cycle plus the WAIT cycles; it stalls in WAIT until conv_valid arrives.
module conv_layer_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int S          = 5,
   parameter int H          = 32,
   parameter int W          = 32,
   localparam int OW        = W - S + 1,
   localparam int OH        = H - S + 1,
   localparam int HALF      = OW / 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   output logic                           busy,
   output logic                           done,
   output logic [5:0]                     rowNum,
   output logic [5:0]                     colSel,
   output logic                           conv_req,
   input  logic                           conv_valid,
   input  logic [0:HALF*DATA_WIDTH-1]     conv_out,
   output logic [0:OH*OW*DATA_WIDTH-1]    fmap
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t state, state_nxt;
   logic   capture;
   logic   last_half;

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      last_half = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (conv_valid) begin
               capture   = 1'b1;
               last_half = (rowNum == 6'(OH - 1)) && (colSel == 6'd1);
               state_nxt = last_half ? DONE : ISSUE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         conv_req <= 1'b0;
         rowNum   <= '0;
         colSel   <= '0;
         fmap     <= '0;
      end else begin
         state    <= state_nxt;
         busy     <= (state_nxt == ISSUE) || (state_nxt == WAIT);
         done     <= (state_nxt == DONE);
         conv_req <= (state_nxt == ISSUE);
         if ((state == IDLE) && start) begin
            rowNum <= '0;
            colSel <= '0;
         end
         if (capture) begin
            for (int j = 0; j < HALF; j++) begin
               fmap[(int'(rowNum) * OW + int'(colSel) * HALF + j) * DATA_WIDTH +: DATA_WIDTH]
                  <= conv_out[j * DATA_WIDTH +: DATA_WIDTH];
            end
            if (colSel == 6'd0) begin
               colSel <= 6'd1;
            end else begin
               colSel <= '0;
               rowNum <= rowNum + 6'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq at S=3, H=6, W=6 with a scoreboard of expected
// launch cycles, row/half selects and captured pixels.
module tb_conv_layer_seq;
   localparam int DW   = 16;
   localparam int S    = 3;
   localparam int H    = 6;
   localparam int W    = 6;
   localparam int OW   = 4;
   localparam int OH   = 4;
   localparam int HALF = 2;
   localparam int NPIX = OW * OH;
   localparam logic [DW-1:0] JUNK = 16'hDEAD;

   logic                clk, rst, start, busy, done, conv_req, conv_valid;
   logic [5:0]          rowNum, colSel;
   logic [0:HALF*DW-1]  conv_out;
   logic [0:NPIX*DW-1]  fmap;

   typedef struct {
      int              idx;
      logic [DW-1:0]   val;
   } pix_t;

   pix_t          pix_q[$];
   int            req_q[$];
   int            hs_q[$];
   logic [DW-1:0] exp_fmap [NPIX];
   int            n_assert = 0;
   int            n_fail   = 0;

   conv_layer_seq #(.DATA_WIDTH(DW), .S(S), .H(H), .W(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .rowNum     (rowNum),
      .colSel     (colSel),
      .conv_req   (conv_req),
      .conv_valid (conv_valid),
      .conv_out   (conv_out),
      .fmap       (fmap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] pix(input int idx);
      return fmap[idx*DW +: DW];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic drive_junk(input bit v);
      conv_valid = v;
      conv_out   = {JUNK, JUNK};
   endtask

   task automatic check_fmap_model(input string tag);
      for (int i = 0; i < NPIX; i++) chk($sformatf("%s_px%0d", tag, i), pix(i), exp_fmap[i]);
   endtask

   // Called in "cycle 0" of a pass; the conv responder answers the cycle after each conv_req.
   task automatic run_pass(input int stall, input bit spurious, input bit hold_start,
                           input int base, input int abort_cyc);
      int   c, hs_drv, stall_left, cur_r, cur_cs, e_hs, exp_done;
      bit   pend, saw_done;
      pix_t p;
      exp_done = 2 * 2 * OH + 1 + stall;
      for (int k = 0; k < 2 * OH; k++) begin
         req_q.push_back(1 + 2 * k + ((k > 0) ? stall : 0));
         hs_q.push_back(k);
      end
      start = 1'b1;
      drive_junk(spurious);
      c = 0; pend = 0; saw_done = 0; stall_left = stall; hs_drv = 0; cur_r = 0; cur_cs = 0;
      while (!saw_done && c < 100) begin
         step();
         c++;
         if (conv_req) begin
            if (req_q.size() == 0) begin
               chk("conv_req_extra", 1, 0);
            end else begin
               chk("conv_req_cycle", c, req_q.pop_front());
               e_hs = hs_q.pop_front();
               chk("rowNum_at_req", rowNum, e_hs / 2);
               chk("colSel_at_req", colSel, e_hs % 2);
            end
         end
         if (done) begin
            chk("done_cycle", c, exp_done);
            chk("busy_in_done", busy, 0);
            saw_done = 1;
         end
         if (c == abort_cyc) begin
            rst   = 1'b1;
            start = 1'b0;
            drive_junk(0);
            step();
            chk("abort_busy", busy, 0);
            chk("abort_rowNum", rowNum, 0);
            chk("abort_colSel", colSel, 0);
            chk("abort_done", done, 0);
            chk("abort_conv_req", conv_req, 0);
            chk("abort_fmap_zero", fmap == '0, 1);
            rst = 1'b0;
            req_q.delete();
            hs_q.delete();
            pix_q.delete();
            foreach (exp_fmap[i]) exp_fmap[i] = '0;
            return;
         end
         start = hold_start | spurious;
         drive_junk(spurious);
         if (pend) begin
            if (stall_left > 0) begin
               stall_left--;
               chk("stall_busy", busy, 1);
               chk("stall_rowNum", rowNum, cur_r);
               chk("stall_colSel", colSel, cur_cs);
               chk("stall_no_req", conv_req, 0);
            end else begin
               conv_valid = 1'b1;
               for (int j = 0; j < HALF; j++) begin
                  p.idx = cur_r * OW + cur_cs * HALF + j;
                  p.val = DW'(base + 100 * cur_r + 10 * cur_cs + j);
                  conv_out[j*DW +: DW] = p.val;
                  pix_q.push_back(p);
                  exp_fmap[p.idx] = p.val;
               end
               pend = 0;
            end
         end
         if (conv_req) begin
            pend   = 1;
            cur_r  = hs_drv / 2;
            cur_cs = hs_drv % 2;
            hs_drv++;
         end
      end
      chk("pass_done_seen", saw_done, 1);
      chk("all_req_issued", req_q.size(), 0);
      req_q.delete();
      hs_q.delete();
      step();
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_no_req", conv_req, 0);
      start = hold_start;
      drive_junk(spurious);
      while (pix_q.size() > 0) begin
         p = pix_q.pop_front();
         chk($sformatf("fmap_px%0d", p.idx), pix(p.idx), p.val);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      drive_junk(0);
      foreach (exp_fmap[i]) exp_fmap[i] = '0;
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_conv_req", conv_req, 0);
      chk("rst_rowNum", rowNum, 0);
      chk("rst_colSel", colSel, 0);
      chk("rst_fmap_zero", fmap == '0, 1);
      rst = 1'b0;
      step();
      chk("idle_no_start", busy, 0);

      // Plain full pass, then spot-check two named pixels.
      run_pass(0, 0, 0, 0, -1);
      chk("fmap_r2c3", pix(2 * OW + 3), 211);
      chk("fmap_r3c0", pix(3 * OW + 0), 300);

      // First WAIT stalled five cycles.
      run_pass(5, 0, 0, 500, -1);

      // Spurious start/conv_valid in every non-WAIT state, then idle with junk valid.
      run_pass(0, 1, 0, 1000, -1);
      drive_junk(1);
      repeat (3) begin
         step();
         chk("spur_idle_busy", busy, 0);
         chk("spur_idle_req", conv_req, 0);
      end
      drive_junk(0);
      check_fmap_model("spur_keep");

      // Reset in the middle of a pass, junk valid while idle at row 0, then a clean pass.
      run_pass(0, 0, 0, 2000, 8);
      drive_junk(1);
      repeat (4) begin
         step();
         chk("abort_no_done", done, 0);
         chk("abort_idle_busy", busy, 0);
      end
      drive_junk(0);
      chk("abort_fmap_stays_zero", fmap == '0, 1);
      run_pass(0, 0, 0, 3000, -1);

      // Back-to-back passes with start held high.
      run_pass(0, 0, 1, 4000, -1);
      run_pass(0, 0, 1, 5000, -1);
      start = 1'b0;
      step();
      step();
      chk("b2b_stopped", busy, 0);
      check_fmap_model("b2b_final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/conv_layer_seq.md
CONV_LAYER_SEQ -- requirements
Module: conv_layer_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of one pixel/result word.
REQ-002 SHALL have parameter S, default 5, the filter size.
REQ-003 SHALL have parameter H, default 32, the input image height.
REQ-004 SHALL have parameter W, default 32, the input image width; W-S+1 SHALL be even.
REQ-005 SHALL use derived localparams OW=W-S+1, OH=H-S+1, HALF=OW/2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port start, input, 1 bit: request one full layer pass.
REQ-009 SHALL have port busy, output, 1 bit: high while a pass is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at pass completion.
REQ-011 SHALL have port rowNum, output, [5:0]: output-row index driven to the receptive-field selector.
REQ-012 SHALL have port colSel, output, [5:0]: half-row select driven to the selector (0 = first half, 1 = second half).
REQ-013 SHALL have port conv_req, output, 1 bit: one-cycle launch pulse to the conv units.
REQ-014 SHALL have port conv_valid, input, 1 bit: conv units' half-row results are valid.
REQ-015 SHALL have port conv_out, input, [0:HALF*DATA_WIDTH-1]: HALF results, word j at bits j*DATA_WIDTH+:DATA_WIDTH.
REQ-016 SHALL have port fmap, output, [0:OH*OW*DATA_WIDTH-1]: registered output feature map, pixel (r,c) at bits (r*OW+c)*DATA_WIDTH+:DATA_WIDTH.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT, DONE.
REQ-018 IDLE: start=1 SHALL clear rowNum and colSel to 0 and go to ISSUE; start=0 SHALL remain in IDLE.
REQ-019 ISSUE SHALL last exactly one cycle, assert conv_req=1, and go to WAIT.
REQ-020 WAIT: conv_valid=0 SHALL hold in WAIT with no timeout.
REQ-021 WAIT with conv_valid=1 SHALL, on that edge, write conv_out word j into fmap pixel (rowNum, colSel*HALF+j) for j=0..HALF-1.
REQ-022 WAIT with conv_valid=1 SHALL advance: colSel=0 goes to colSel=1; colSel=1 goes to colSel=0 with rowNum+1.
REQ-023 The write in WAIT with conv_valid=1 SHALL go to DONE if rowNum=OH-1 and colSel=1, else to ISSUE.
REQ-024 DONE SHALL last one cycle, assert done=1, and return to IDLE.
REQ-025 busy SHALL be 1 in ISSUE and WAIT, 0 in IDLE and DONE.
REQ-026 rowNum and colSel SHALL be stable from ISSUE through the WAIT capture edge, because the selector output is combinational.
REQ-027 start while not in IDLE SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-028 conv_valid outside WAIT SHALL be ignored and SHALL NOT modify fmap.
REQ-029 fmap pixels SHALL retain their values between passes; a new pass SHALL overwrite all pixels and clear none beforehand.
REQ-030 Per-half-row latency SHALL be 1 (ISSUE) plus the number of WAIT cycles; minimum pass length with immediate conv_valid SHALL be 2*2*OH cycles, followed by the DONE cycle.
REQ-031 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-032 rst=1 SHALL force the IDLE state on the next edge, with priority over all other inputs.
REQ-033 Reset values SHALL be busy=0, done=0, conv_req=0, rowNum=0, colSel=0, and fmap all zeros.
REQ-034 rst asserted mid-pass SHALL abort the pass: no done pulse, and fmap cleared to zero.

Verification (S=3, H=6, W=6 -> OW=4, OH=4, HALF=2)
REQ-035 Full pass: start at cycle 0, conv_valid the cycle after each conv_req, conv_out={100*r+10*cs, 100*r+10*cs+1} -> conv_req at cycles 1,3,...,15; done=1 at cycle 17 only; fmap(2,3)=211, fmap(3,0)=300.
REQ-036 Stalled conv: conv_valid held low 5 cycles in the first WAIT -> rowNum=0 and colSel=0 stable, busy=1, single conv_req; done at cycle 22.
REQ-037 Spurious inputs: start pulses and conv_valid=1 asserted in IDLE, ISSUE and DONE -> no restart, fmap unchanged, pass sequencing identical to REQ-035.
REQ-038 Mid-pass reset: rst at cycle 8 -> next cycle busy=0, rowNum=0, fmap all zero, no done; a subsequent start performs a full pass correctly.
REQ-039 Back-to-back passes: start held high continuously -> second pass begins at the cycle after DONE returns to IDLE, and the second pass's fmap overwrites the first's values.
